// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
// Shares one lower-memory port between the L1 instruction cache (read-only)
// and the L1 data cache (read/write). One downstream transaction at a time,
// round-robin on ties, grant held until the owner drops its request.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a BUSY watchdog
// (TIMEOUT_CYCLES) and a sticky timeout_err output.
module l1_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_mem_request,
   input  logic [ADDR_WIDTH-1:0] i_mem_address,
   output logic [DATA_WIDTH-1:0] i_mem_response_data,
   output logic                  i_mem_ready,
   input  logic                  d_mem_request,
   input  logic                  d_mem_write_enable,
   input  logic [ADDR_WIDTH-1:0] d_mem_address,
   input  logic [DATA_WIDTH-1:0] d_mem_write_data,
   output logic [DATA_WIDTH-1:0] d_mem_response_data,
   output logic                  d_mem_ready,
   output logic                  mem_request,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_response_data,
   input  logic                  mem_ready,
   output logic [1:0]            grant_owner
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   output logic                  timeout_err
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_I    = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;

`ifdef MEM_ARB_TIMEOUT_EN
   // Counter only has to reach TIMEOUT_CYCLES-1 before the watchdog fires.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] timeout_count_reg;
`endif

   logic [1:0] state_reg;
   logic       last_grant_d_reg;   // 1 = D-side was granted most recently
   logic       grant_d;
   logic       grant_i;
   logic       owner_request;

   // Tie goes to the side that was not granted last; a lone request always wins.
   always_comb begin
      grant_d       = d_mem_request && (!i_mem_request || !last_grant_d_reg);
      grant_i       = i_mem_request && !grant_d;
      owner_request = (grant_owner == OWN_D) ? d_mem_request : i_mem_request;
   end

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg           <= ST_IDLE;
         last_grant_d_reg    <= 1'b0;
         grant_owner         <= OWN_NONE;
         mem_request         <= 1'b0;
         mem_write_enable    <= 1'b0;
         mem_address         <= '0;
         mem_write_data      <= '0;
         i_mem_response_data <= '0;
         i_mem_ready         <= 1'b0;
         d_mem_response_data <= '0;
         d_mem_ready         <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         timeout_count_reg   <= '0;
         timeout_err         <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_d) begin
                  mem_request      <= 1'b1;
                  mem_write_enable <= d_mem_write_enable;
                  mem_address      <= d_mem_address;
                  mem_write_data   <= d_mem_write_data;
                  grant_owner      <= OWN_D;
                  last_grant_d_reg <= 1'b1;
                  state_reg        <= ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                  timeout_count_reg <= '0;
`endif
               end else if (grant_i) begin
                  mem_request      <= 1'b1;
                  mem_write_enable <= 1'b0;
                  mem_address      <= i_mem_address;
                  mem_write_data   <= '0;
                  grant_owner      <= OWN_I;
                  last_grant_d_reg <= 1'b0;
                  state_reg        <= ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                  timeout_count_reg <= '0;
`endif
               end
            end
            ST_BUSY: begin
               // Downstream fields stay latched; owner-side input changes are ignored.
               if (mem_ready) begin
                  mem_request      <= 1'b0;
                  mem_write_enable <= 1'b0;
                  if (grant_owner == OWN_D) begin
                     d_mem_response_data <= mem_response_data;
                     d_mem_ready         <= 1'b1;
                  end else begin
                     i_mem_response_data <= mem_response_data;
                     i_mem_ready         <= 1'b1;
                  end
                  state_reg <= ST_DONE;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (timeout_count_reg == CNT_LAST) begin
                  mem_request      <= 1'b0;
                  mem_write_enable <= 1'b0;
                  timeout_err      <= 1'b1;
                  if (grant_owner == OWN_D) begin
                     d_mem_response_data <= '0;
                     d_mem_ready         <= 1'b1;
                  end else begin
                     i_mem_response_data <= '0;
                     i_mem_ready         <= 1'b1;
                  end
                  state_reg <= ST_DONE;
               end else begin
                  timeout_count_reg <= timeout_count_reg + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               // Hold the grant until the owner lets go, so a stale request is not re-served.
               i_mem_ready <= 1'b0;
               d_mem_ready <= 1'b0;
               if (!owner_request) begin
                  grant_owner <= OWN_NONE;
                  state_reg   <= ST_IDLE;
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               grant_owner <= OWN_NONE;
               mem_request <= 1'b0;
            end
         endcase
      end
   end

endmodule
